dmem_responder: RTL and testbench

- Data-memory responder on the memory side of the MEM stage.
- Consumes the load/store controls produced by decode: read enable plus read mask, write enable plus write strobe, together with the ALU-computed byte address.
- Serves each request from an internal word array with configurable wait states and returns read data over a valid/ready response channel.
- Flags illegal requests: misaligned, out-of-range, or both reading and writing.

---
 rtl/dmem_responder.sv | 180 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the MEM stage. Accepts one load/store request at
//   a time, serves it from an internal word array after LATENCY wait cycles and
//   returns the result on a valid/ready response channel.
//
//   Optional feature macro: DMEM_RESPONDER_ERR_EN
//     defined   : misaligned, out-of-range and read+write requests raise rsp_err_o
//                 and never modify the array.
//     undefined : rsp_err_o is tied 0, the word index wraps modulo DEPTH_WORDS,
//                 bytes shifted past lane 3 are dropped, and a read+write request
//                 writes and returns the pre-write word.
//
//   Ports
//     clk_i        clock, rising edge
//     rst_ni       asynchronous active-low reset
//     req_valid_i  request present          req_ready_o  request can be accepted
//     req_addr_i   byte address             req_ren_i    load request
//     req_rmask_i  load byte mask           req_wen_i    store request
//     req_wstrb_i  store byte strobe        req_wdata_i  store data (right-aligned)
//     rsp_valid_o  response present         rsp_ready_i  consumer takes response
//     rsp_rdata_o  load data (right-aligned, unselected bytes zero)
//     rsp_err_o    request was illegal
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_ren_i,
  input  logic [3:0]  req_rmask_i,
  input  logic        req_wen_i,
  input  logic [3:0]  req_wstrb_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic [1:0]       offset;
  logic [4:0]       shamt;
  logic [IDX_W-1:0] idx;
  logic             req_err;
  logic [3:0]       wmask;
  logic [31:0]      wdata_sh;
  logic [31:0]      rd_word;
  logic [31:0]      rd_mask32;
  logic [31:0]      load_data;

  assign accept = req_valid_i && req_ready_o;
  assign offset = req_addr_i[1:0];
  assign shamt  = {offset, 3'b000};

`ifdef DMEM_RESPONDER_ERR_EN
  logic [31:0] rel_addr;
  logic [3:0]  sel_mask;
  logic [6:0]  eff_mask;
  logic        in_range;

  // Subtracting the base makes addresses below BASE_ADDR wrap to huge values,
  // so one unsigned compare covers both ends of the window.
  assign rel_addr = req_addr_i - BASE_ADDR;
  assign in_range = rel_addr < 32'(4 * DEPTH_WORDS);
  assign idx      = rel_addr[IDX_W+1:2];
  assign sel_mask = req_ren_i ? req_rmask_i : req_wstrb_i;
  assign eff_mask = {3'b000, sel_mask} << offset;
  assign req_err  = (|eff_mask[6:4]) || !in_range || (req_ren_i && req_wen_i);
`else
  logic unused_addr;

  // BASE_ADDR is aligned to the array size, so the low address bits already
  // give the wrapped word index.
  assign idx         = req_addr_i[IDX_W+1:2];
  assign req_err     = 1'b0;
  assign unused_addr = ^req_addr_i[31:IDX_W+2];
`endif

  // Strobe bits shifted beyond lane 3 fall off the 4-bit result.
  assign wmask    = 4'(req_wstrb_i << offset);
  assign wdata_sh = req_wdata_i << shamt;
  assign rd_word  = mem[idx];
  assign rd_mask32 = {{8{req_rmask_i[3]}}, {8{req_rmask_i[2]}},
                      {8{req_rmask_i[1]}}, {8{req_rmask_i[0]}}};
  assign load_data = (req_ren_i && !req_err) ? ((rd_word >> shamt) & rd_mask32) : 32'h0;

  // State register and wait counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: one request in flight, LATENCY edges spent in WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY != 0) begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; ready is masked by reset so it reads 0 during reset.
  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE:    req_ready_o = rst_ni;
      RESP:    rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Response payload is captured at acceptance and held until the next one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= load_data;
      err_q   <= req_err;
    end
  end

  // Array write at the acceptance edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && req_wen_i && !req_err) begin
      for (int k = 0; k < 4; k++) begin
        if (wmask[k]) begin
          mem[idx][8*k +: 8] <= wdata_sh[8*k +: 8];
        end
      end
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Table-driven bench for dmem_responder (DEPTH_WORDS=16, LATENCY=1,
//   BASE_ADDR=0) plus hand-written stall and mid-operation reset sequences.
//   Expectations follow DMEM_RESPONDER_ERR_EN when it is defined for the build.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT   = 1;
  localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef DMEM_RESPONDER_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        ren;
    logic [3:0]  rmask;
    logic        wen;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr = 32'h0;
  logic        req_ren = 1'b0;
  logic [3:0]  req_rmask = 4'h0;
  logic        req_wen = 1'b0;
  logic [3:0]  req_wstrb = 4'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid_o;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr),
    .req_ren_i  (req_ren),
    .req_rmask_i(req_rmask),
    .req_wen_i  (req_wen),
    .req_wstrb_i(req_wstrb),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input string name, input logic [31:0] addr,
                                 input logic ren, input logic [3:0] rmask,
                                 input logic wen, input logic [3:0] wstrb,
                                 input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                 input logic exp_err);
    vec_t v;
    v.name = name; v.addr = addr; v.ren = ren; v.rmask = rmask; v.wen = wen;
    v.wstrb = wstrb; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one request and return once it has been accepted (just after the edge).
  task automatic issueOnly(input vec_t v);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_addr  = v.addr;
    req_ren   = v.ren;
    req_rmask = v.rmask;
    req_wen   = v.wen;
    req_wstrb = v.wstrb;
    req_wdata = v.wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Wait (bounded) for the response; lat counts negedges after acceptance.
  task automatic waitResponse(output int lat);
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (rsp_valid_o) break;
    end
  endtask

  task automatic applyStimulus(input vec_t v, output logic [31:0] rd, output logic er,
                               output int lat);
    issueOnly(v);
    waitResponse(lat);
    rd = rsp_rdata_o;
    er = rsp_err_o;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] word10;

    word10 = ERR_ON ? 32'hAA22_3344 : 32'hCC22_3344;

    vecs.push_back(mkVec("sw_deadbeef", 32'h10, 0, 4'h0, 1, 4'hF, 32'hDEAD_BEEF, 32'h0, 0));
    vecs.push_back(mkVec("lw_deadbeef", 32'h10, 1, 4'hF, 0, 4'h0, 32'h0, 32'hDEAD_BEEF, 0));
    vecs.push_back(mkVec("sw_11223344", 32'h10, 0, 4'h0, 1, 4'hF, 32'h1122_3344, 32'h0, 0));
    vecs.push_back(mkVec("sb_aa_at13", 32'h13, 0, 4'h0, 1, 4'h1, 32'h0000_00AA, 32'h0, 0));
    vecs.push_back(mkVec("lw_after_sb", 32'h10, 1, 4'hF, 0, 4'h0, 32'h0, 32'hAA22_3344, 0));
    vecs.push_back(mkVec("lbu_at13", 32'h13, 1, 4'h1, 0, 4'h0, 32'h0, 32'h0000_00AA, 0));
    vecs.push_back(mkVec("lh_at12", 32'h12, 1, 4'h3, 0, 4'h0, 32'h0, 32'h0000_AA22, 0));
    vecs.push_back(mkVec("lh_at13_misal", 32'h13, 1, 4'h3, 0, 4'h0, 32'h0,
                         ERR_ON ? 32'h0 : 32'h0000_00AA, ERR_ON));
    vecs.push_back(mkVec("sh_at13_misal", 32'h13, 0, 4'h0, 1, 4'h3, 32'h0000_BBCC, 32'h0, ERR_ON));
    vecs.push_back(mkVec("lw_after_misal", 32'h10, 1, 4'hF, 0, 4'h0, 32'h0, word10, 0));
    vecs.push_back(mkVec("lw_at11_misal", 32'h11, 1, 4'hF, 0, 4'h0, 32'h0,
                         ERR_ON ? 32'h0 : (word10 >> 8), ERR_ON));
    vecs.push_back(mkVec("sw_word0", 32'h00, 0, 4'h0, 1, 4'hF, 32'h0BAD_F00D, 32'h0, 0));
    vecs.push_back(mkVec("lw_oor_top", 32'h40, 1, 4'hF, 0, 4'h0, 32'h0,
                         ERR_ON ? 32'h0 : 32'h0BAD_F00D, ERR_ON));
    vecs.push_back(mkVec("sw_oor_top", 32'h40, 0, 4'h0, 1, 4'hF, 32'h1234_5678, 32'h0, ERR_ON));
    vecs.push_back(mkVec("lw_word0", 32'h00, 1, 4'hF, 0, 4'h0, 32'h0,
                         ERR_ON ? 32'h0BAD_F00D : 32'h1234_5678, 0));
    vecs.push_back(mkVec("sw_cafef00d", 32'h08, 0, 4'h0, 1, 4'hF, 32'hCAFE_F00D, 32'h0, 0));
    vecs.push_back(mkVec("ren_and_wen", 32'h08, 1, 4'hF, 1, 4'hF, 32'h0102_0304,
                         ERR_ON ? 32'h0 : 32'hCAFE_F00D, ERR_ON));
    vecs.push_back(mkVec("lw_after_rw", 32'h08, 1, 4'hF, 0, 4'h0, 32'h0,
                         ERR_ON ? 32'hCAFE_F00D : 32'h0102_0304, 0));
    vecs.push_back(mkVec("no_ren_no_wen", 32'h08, 0, 4'hF, 0, 4'hF, 32'hFFFF_FFFF, 32'h0, 0));
    vecs.push_back(mkVec("sw_5a5a", 32'h0C, 0, 4'h0, 1, 4'hF, 32'h5A5A_5A5A, 32'h0, 0));
    vecs.push_back(mkVec("sw_zero_strb", 32'h0C, 0, 4'h0, 1, 4'h0, 32'hFFFF_FFFF, 32'h0, 0));
    vecs.push_back(mkVec("lw_after_nostrb", 32'h0C, 1, 4'hF, 0, 4'h0, 32'h0, 32'h5A5A_5A5A, 0));

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset req_ready", 32'(req_ready_o), 32'h0);
    checkOutput("reset rsp_valid", 32'(rsp_valid_o), 32'h0);
    checkOutput("reset rsp_rdata", rsp_rdata_o, 32'h0);
    checkOutput("reset rsp_err", 32'(rsp_err_o), 32'h0);
    rst_n = 1'b1;
    #1 checkOutput("post-reset req_ready", 32'(req_ready_o), 32'h1);

    // Directed vector table.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i], rd, er, lat);
      checkOutput({vecs[i].name, " rdata"}, rd, vecs[i].exp_rdata);
      checkOutput({vecs[i].name, " err"}, 32'(er), 32'(vecs[i].exp_err));
      checkOutput({vecs[i].name, " latency"}, 32'(lat), 32'(LAT + 1));
    end

    // Consumer stall: response must hold for 5 cycles with rsp_ready low.
    issueOnly(mkVec("stall_lw", 32'h10, 1, 4'hF, 0, 4'h0, 32'h0, 32'h0, 0));
    waitResponse(lat);
    checkOutput("stall latency", 32'(lat), 32'(LAT + 1));
    for (int c = 0; c < 5; c++) begin
      checkOutput("stall rsp_valid", 32'(rsp_valid_o), 32'h1);
      checkOutput("stall rsp_rdata", rsp_rdata_o, word10);
      checkOutput("stall rsp_err", 32'(rsp_err_o), 32'h0);
      checkOutput("stall req_ready", 32'(req_ready_o), 32'h0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("release req_ready", 32'(req_ready_o), 32'h1);
    checkOutput("release rsp_valid", 32'(rsp_valid_o), 32'h0);
    applyStimulus(mkVec("post_stall_lw", 32'h0C, 1, 4'hF, 0, 4'h0, 32'h0, 32'h0, 0), rd, er, lat);
    checkOutput("post_stall rdata", rd, 32'h5A5A_5A5A);
    checkOutput("post_stall latency", 32'(lat), 32'(LAT + 1));

    // Reset during WAIT: response discarded, store stays committed.
    issueOnly(mkVec("sw_55", 32'h20, 0, 4'h0, 1, 4'hF, 32'h0000_0055, 32'h0, 0));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset rsp_valid", 32'(rsp_valid_o), 32'h0);
    checkOutput("midreset req_ready", 32'(req_ready_o), 32'h0);
    checkOutput("midreset rsp_rdata", rsp_rdata_o, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("after reset rsp_valid", 32'(rsp_valid_o), 32'h0);
      checkOutput("after reset req_ready", 32'(req_ready_o), 32'h1);
    end
    applyStimulus(mkVec("lw_55", 32'h20, 1, 4'hF, 0, 4'h0, 32'h0, 32'h0, 0), rd, er, lat);
    checkOutput("lw_55 rdata", rd, 32'h0000_0055);
    checkOutput("lw_55 err", 32'(er), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
